// File: rtl/op_accum.sv
// -----------------------------------------------------------------------------
// op_accum -- streaming frame accumulator
//
// Sums up to LEN N-bit samples per frame with the same signed/unsigned and
// wrap/saturate rules as op_add. It then presents the frame sum, the sticky
// overflow/underflow flags and the sample count on a valid/ready output port.
// A result waiting in HOLD back-pressures the input. When the result is taken,
// the input can start the next frame in the same cycle.
//
// Optional build macro:
//   OP_ACCUM_EVTCNT_EN  adds out_evt, which counts the adds in the frame that
//                       raised ov or uv.
//
// Ports:
//   clk        in   1      clock, posedge
//   rst_n      in   1      asynchronous active-low reset
//   clr        in   1      synchronous clear of the partial frame and the held result
//   in_valid   in   1      sample valid
//   in_ready   out  1      sample ready (combinational from state, out_ready, clr)
//   in_data    in   N      sample value
//   in_last    in   1      closes the frame with this sample
//   out_valid  out  1      frame result valid
//   out_ready  in   1      downstream accepts the result
//   out_sum    out  N      frame sum
//   out_ov     out  1      sticky overflow of the frame
//   out_uv     out  1      sticky underflow of the frame
//   out_cnt    out  CNT_W  samples in the frame (1..LEN)
//   out_evt    out  CNT_W  adds that raised ov/uv (OP_ACCUM_EVTCNT_EN only)
// -----------------------------------------------------------------------------
module op_accum #(
  parameter int N        = 8,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 1,
  parameter int LEN      = 4,
  parameter int CNT_W    = $clog2(LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_sum,
  output logic             out_ov,
  output logic             out_uv,
  output logic [CNT_W-1:0] out_cnt
`ifdef OP_ACCUM_EVTCNT_EN
  ,
  output logic [CNT_W-1:0] out_evt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [N-1:0]     SMAX  = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]     SMIN  = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0]     UMAX  = {N{1'b1}};
  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LEN);

  state_t           state_q;
  logic [N-1:0]     acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ov_q, uv_q;
  logic             out_valid_q;
  logic [N-1:0]     out_sum_q;
  logic             out_ov_q, out_uv_q;
  logic [CNT_W-1:0] out_cnt_q;

  logic             accept;
  logic             first;
  logic [N:0]       sum_ext;
  logic             add_ov, add_uv;
  logic [N-1:0]     add_res;
  logic [N-1:0]     acc_d;
  logic [CNT_W-1:0] cnt_d;
  logic             ov_d, uv_d;
  logic             close_d;

`ifdef OP_ACCUM_EVTCNT_EN
  logic [CNT_W-1:0] evt_q, evt_d, out_evt_q;
`endif

  // HOLD can only accept when the held result leaves in the same cycle.
  // That keeps the output registers from being overwritten while they wait.
  assign in_ready  = !clr && ((state_q != HOLD) || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_ov    = out_ov_q;
  assign out_uv    = out_uv_q;
  assign out_cnt   = out_cnt_q;
`ifdef OP_ACCUM_EVTCNT_EN
  assign out_evt   = out_evt_q;
`endif

  // Adder plus the next frame values, assuming this cycle accepts a sample.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    sum_ext = {1'b0, acc_q} + {1'b0, in_data};
    add_ov  = 1'b0;
    add_uv  = 1'b0;
    add_res = sum_ext[N-1:0];

    if (SIGNED != 0) begin
      add_ov = !acc_q[N-1] && !in_data[N-1] &&  sum_ext[N-1];
      add_uv =  acc_q[N-1] &&  in_data[N-1] && !sum_ext[N-1];
    end else begin
      add_ov = sum_ext[N];
    end

    if (SATURATE != 0) begin
      if (add_ov)      add_res = (SIGNED != 0) ? SMAX : UMAX;
      else if (add_uv) add_res = SMIN;
    end

    // A sample taken outside ACCUM always opens a new frame.
    first   = (state_q != ACCUM);
    acc_d   = first ? in_data : add_res;
    ov_d    = !first && (ov_q || add_ov);
    uv_d    = !first && (uv_q || add_uv);
    cnt_d   = first ? CNT_W'(1) : cnt_q + CNT_W'(1);
    close_d = in_last || (cnt_d == LEN_C);
`ifdef OP_ACCUM_EVTCNT_EN
    evt_d   = first ? '0 : evt_q + CNT_W'(add_ov || add_uv);
`endif
  end

  // FSM, frame state and registered outputs.
  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples the pre-edge values, whatever the statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ov_q        <= 1'b0;
      uv_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ov_q    <= 1'b0;
      out_uv_q    <= 1'b0;
      out_cnt_q   <= '0;
`ifdef OP_ACCUM_EVTCNT_EN
      evt_q       <= '0;
      out_evt_q   <= '0;
`endif
    end else if (clr) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ov_q        <= 1'b0;
      uv_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ov_q    <= 1'b0;
      out_uv_q    <= 1'b0;
      out_cnt_q   <= '0;
`ifdef OP_ACCUM_EVTCNT_EN
      evt_q       <= '0;
      out_evt_q   <= '0;
`endif
    end else begin
      // Result taken: drop it. An accept in the same cycle overrides this below.
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
        state_q     <= IDLE;
      end

      if (accept) begin
        acc_q <= acc_d;
        cnt_q <= cnt_d;
        ov_q  <= ov_d;
        uv_q  <= uv_d;
`ifdef OP_ACCUM_EVTCNT_EN
        evt_q <= evt_d;
`endif
        if (close_d) begin
          state_q     <= HOLD;
          out_valid_q <= 1'b1;
          out_sum_q   <= acc_d;
          out_ov_q    <= ov_d;
          out_uv_q    <= uv_d;
          out_cnt_q   <= cnt_d;
`ifdef OP_ACCUM_EVTCNT_EN
          out_evt_q   <= evt_d;
`endif
        end else begin
          state_q <= ACCUM;
        end
      end
    end
  end

endmodule

// File: tb/tb_op_accum.sv
// -----------------------------------------------------------------------------
// tb_op_accum -- self-checking bench for op_accum (N=8, LEN=4)
//
// Three instances run on shared stimulus:
//   dut 0: SIGNED=1 SATURATE=1
//   dut 1: SIGNED=0 SATURATE=1
//   dut 2: SIGNED=1 SATURATE=0
// A frame-level model keeps the accepted samples of the open frame. When the
// frame closes, it folds them with plain integer arithmetic. Directed tests
// also pin the captured results to hand-computed constants.
// -----------------------------------------------------------------------------
module tb_op_accum;

  localparam int N    = 8;
  localparam int LEN  = 4;
  localparam int CW   = $clog2(LEN + 1);
  localparam int NCFG = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic         out_ready = 1'b1;
  logic [N-1:0] in_data = '0;

  logic          rdy [NCFG];
  logic          vld [NCFG];
  logic          ov  [NCFG];
  logic          uv  [NCFG];
  logic [N-1:0]  sum [NCFG];
  logic [CW-1:0] cnt [NCFG];
`ifdef OP_ACCUM_EVTCNT_EN
  logic [CW-1:0] evt [NCFG];
`endif

  always #5 clk = ~clk;

  op_accum #(.N(N), .SIGNED(1), .SATURATE(1), .LEN(LEN)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(rdy[0]), .in_data(in_data), .in_last(in_last),
    .out_valid(vld[0]), .out_ready(out_ready), .out_sum(sum[0]),
    .out_ov(ov[0]), .out_uv(uv[0]), .out_cnt(cnt[0])
`ifdef OP_ACCUM_EVTCNT_EN
    , .out_evt(evt[0])
`endif
  );

  op_accum #(.N(N), .SIGNED(0), .SATURATE(1), .LEN(LEN)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(rdy[1]), .in_data(in_data), .in_last(in_last),
    .out_valid(vld[1]), .out_ready(out_ready), .out_sum(sum[1]),
    .out_ov(ov[1]), .out_uv(uv[1]), .out_cnt(cnt[1])
`ifdef OP_ACCUM_EVTCNT_EN
    , .out_evt(evt[1])
`endif
  );

  op_accum #(.N(N), .SIGNED(1), .SATURATE(0), .LEN(LEN)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(rdy[2]), .in_data(in_data), .in_last(in_last),
    .out_valid(vld[2]), .out_ready(out_ready), .out_sum(sum[2]),
    .out_ov(ov[2]), .out_uv(uv[2]), .out_cnt(cnt[2])
`ifdef OP_ACCUM_EVTCNT_EN
    , .out_evt(evt[2])
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  logic [N-1:0] frame [$];
  bit           pend = 1'b0;
  logic [N-1:0] e_sum [NCFG];
  bit           e_ov  [NCFG];
  bit           e_uv  [NCFG];
  int           e_evt [NCFG];
  int           e_cnt;

  // Values taken from the DUTs at each output transfer.
  logic [N-1:0] last_sum [NCFG];
  bit           last_ov  [NCFG];
  bit           last_uv  [NCFG];
  int           last_cnt [NCFG];
  int           last_evt [NCFG];
  int           n_xfer = 0;

  // Folds the closed frame for configuration cfg, using plain integers.
  function automatic void fold(input int cfg, output logic [N-1:0] s_o,
                               output bit ov_o, output bit uv_o, output int evt_o);
    bit sgn = (cfg != 1);
    bit sat = (cfg != 2);
    int hi  = sgn ? 127 : 255;
    int lo  = sgn ? -128 : 0;
    int acc, b, s;
    acc   = sgn ? int'($signed(frame[0])) : int'(frame[0]);
    ov_o  = 1'b0;
    uv_o  = 1'b0;
    evt_o = 0;
    for (int i = 1; i < frame.size(); i++) begin
      b = sgn ? int'($signed(frame[i])) : int'(frame[i]);
      s = acc + b;
      if (s > hi) begin
        ov_o = 1'b1; evt_o++; s = sat ? hi : s - 256;
      end else if (s < lo) begin
        uv_o = 1'b1; evt_o++; s = sat ? lo : s + 256;
      end
      acc = s;
    end
    s_o = acc[N-1:0];
  endfunction

  // Compare process: check on the falling edge, then advance the model by the
  // rising edge that follows.
  always @(negedge clk) begin
    bit er, xf, ac;
    if (!rst_n) begin
      for (int k = 0; k < NCFG; k++) begin
        check($sformatf("rst_valid[%0d]", k), vld[k], 0);
        check($sformatf("rst_sum[%0d]", k), sum[k], 0);
        check($sformatf("rst_flags[%0d]", k), {ov[k], uv[k]}, 0);
        check($sformatf("rst_cnt[%0d]", k), cnt[k], 0);
`ifdef OP_ACCUM_EVTCNT_EN
        check($sformatf("rst_evt[%0d]", k), evt[k], 0);
`endif
      end
      pend = 1'b0;
      frame.delete();
    end else begin
      er = !clr && (!pend || out_ready);
      for (int k = 0; k < NCFG; k++) begin
        check($sformatf("in_ready[%0d]", k), rdy[k], er);
        check($sformatf("out_valid[%0d]", k), vld[k], pend);
        if (pend) begin
          check($sformatf("out_sum[%0d]", k), sum[k], e_sum[k]);
          check($sformatf("out_ov[%0d]", k), ov[k], e_ov[k]);
          check($sformatf("out_uv[%0d]", k), uv[k], e_uv[k]);
          check($sformatf("out_cnt[%0d]", k), cnt[k], e_cnt);
`ifdef OP_ACCUM_EVTCNT_EN
          check($sformatf("out_evt[%0d]", k), evt[k], e_evt[k]);
`endif
        end
      end
      if (clr) begin
        pend = 1'b0;
        frame.delete();
      end else begin
        xf = pend && out_ready;
        ac = in_valid && er;
        if (xf) begin
          pend = 1'b0;
          n_xfer++;
          for (int k = 0; k < NCFG; k++) begin
            last_sum[k] = sum[k];
            last_ov[k]  = ov[k];
            last_uv[k]  = uv[k];
            last_cnt[k] = int'(cnt[k]);
`ifdef OP_ACCUM_EVTCNT_EN
            last_evt[k] = int'(evt[k]);
`else
            last_evt[k] = 0;
`endif
          end
        end
        if (ac) begin
          frame.push_back(in_data);
          if (in_last || frame.size() == LEN) begin
            for (int k = 0; k < NCFG; k++) fold(k, e_sum[k], e_ov[k], e_uv[k], e_evt[k]);
            e_cnt = frame.size();
            pend  = 1'b1;
            frame.delete();
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [N-1:0] d, input logic l);
    bit ok = 1'b0;
    int tries = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!ok && tries < 50) begin
      @(negedge clk);
      ok = rdy[0];
      tries++;
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("send_accept", ok, 1);
  endtask

  task automatic wait_xfer(input string tag, input int target);
    int tries = 0;
    while (n_xfer < target && tries < 30) begin
      tick();
      tries++;
    end
    tick(); tick(); tick();
    check({tag, "_xfers"}, n_xfer, target);
  endtask

  task automatic expect_last(input string tag, input int k, input logic [N-1:0] s,
                             input bit o, input bit u, input int c);
    check({tag, "_sum"}, last_sum[k], s);
    check({tag, "_ov"}, last_ov[k], o);
    check({tag, "_uv"}, last_uv[k], u);
    check({tag, "_cnt"}, last_cnt[k], c);
  endtask

  int base;

  initial begin
    #2;
    check("reset_out_valid", vld[0], 0);
    check("reset_out_sum", sum[0], 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Test 1: 0x40 x4 with no in_last; LEN closes the frame.
    base = n_xfer;
    for (int i = 0; i < 4; i++) send(8'h40, 1'b0);
    wait_xfer("t1", base + 1);
    expect_last("t1_sat", 0, 8'h7F, 1, 0, 4);
`ifdef OP_ACCUM_EVTCNT_EN
    check("t1_evt", last_evt[0], 3);
`endif
    expect_last("t3_wrap", 2, 8'h00, 1, 0, 4);

    // in_last on the LEN-th sample closes the frame exactly once.
    base = n_xfer;
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 1);
    wait_xfer("t1b", base + 1);
    expect_last("t1b", 0, 8'h0A, 0, 0, 4);

    // Test 2: unsigned saturating.
    base = n_xfer;
    send(8'hF0, 0); send(8'h20, 1);
    wait_xfer("t2", base + 1);
    expect_last("t2_uns", 1, 8'hFF, 1, 0, 2);

    // Test 3b: signed underflow clamps to 0x80.
    base = n_xfer;
    send(8'h80, 0); send(8'hFF, 1);
    wait_xfer("t3b", base + 1);
    expect_last("t3b", 0, 8'h80, 0, 1, 2);

    // Test 4: back-pressure for 5 cycles, then a transfer and an accept in the same cycle.
    base = n_xfer;
    out_ready = 1'b0;
    send(8'h10, 0); send(8'h20, 1);
    in_valid = 1'b1; in_data = 8'h05; in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_hold_valid", vld[0], 1);
      check("t4_hold_sum", sum[0], 8'h30);
      check("t4_hold_ready", rdy[0], 0);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("t4_ready_back", rdy[0], 1);
    tick();
    in_valid = 1'b0;
    send(8'h07, 1);
    wait_xfer("t4", base + 2);
    expect_last("t4", 0, 8'h0C, 0, 0, 2);

    // Test 5: clr drops a partial frame and wins over a valid sample.
    send(8'h01, 0); send(8'h02, 0);
    clr = 1'b1; in_valid = 1'b1; in_data = 8'h55;
    @(negedge clk);
    check("t5_clr_ready", rdy[0], 0);
    tick();
    clr = 1'b0; in_valid = 1'b0;
    base = n_xfer;
    for (int i = 0; i < 4; i++) send(8'h01, 0);
    wait_xfer("t5", base + 1);
    expect_last("t5", 0, 8'h04, 0, 0, 4);

    // Test 6: asynchronous reset during HOLD.
    out_ready = 1'b0;
    send(8'h11, 1);
    check("t6_in_hold", vld[0], 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", vld[0], 0);
    check("t6_async_sum", sum[0], 0);
    check("t6_async_cnt", cnt[0], 0);
    tick(); tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("t6_idle_valid", vld[0], 0);
    check("t6_idle_ready", rdy[0], 1);
    tick();
    base = n_xfer;
    send(8'h22, 0); send(8'h33, 1);
    wait_xfer("t6", base + 1);
    expect_last("t6", 0, 8'h55, 0, 0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
